// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants, state and Booth encodings for the multiply/divide unit
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER = 32;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    DFIX = 3'd3,
    DONE = 3'd4
  } state_e;
  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_e;
  function automatic booth_e booth_sel(input logic q0, input logic qm1);
    return (q0 == qm1) ? NOP : (q0 ? SUB : ADD);
  endfunction
endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: operand/start/result bundle between the execute stage and the multiply/divide unit
interface multdiv_if;
  import multdiv_pkg::*;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mdu_addsub.sv
// mdu_addsub: single add/subtract shared by every multiply and divide step
module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);
  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiplier (radix-2 Booth) and divider (non-restoring)
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);
  import multdiv_pkg::*;
  state_e             state_q, state_d;
  booth_e             sel;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d, m_q, m_d, add_a, add_b, sum;
  logic [WIDTH-1:0]   q_q, q_d, res_q, res_d, mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic qm1_q, qm1_d, div_q, div_d, neg_q, neg_d, dz_q, dz_d, dov_q, dov_d;
  logic exc_q, exc_d, rdy_q, rdy_d, add_sub, start;
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign sel   = booth_sel(q_q[0], qm1_q);
  assign prod  = {acc_q[WIDTH-1:0], q_q};
  assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  mdu_addsub #(.W(WIDTH + 1)) u_addsub (
    .a  (add_a),
    .b  (add_b),
    .sub(add_sub),
    .y  (sum)
  );
  // route the shared adder: Booth step, division step, remainder restore, quotient negation
  always_comb begin
    add_a   = acc_q;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == MULT) begin
      add_b   = (sel == NOP) ? '0 : m_q;
      add_sub = sel == SUB;
    end else if (state_q == DIV) begin
      add_a   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      add_b   = m_q;
      add_sub = ~acc_q[WIDTH];
    end else if (state_q == DFIX) begin
      add_b = acc_q[WIDTH] ? m_q : '0;
    end else if (state_q == DONE) begin
      add_a   = '0;
      add_b   = {1'b0, q_q};
      add_sub = 1'b1;
    end
  end
  // next state, iteration datapath, completion and (re)start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    div_d   = div_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    dov_d   = dov_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    case (state_q)
      MULT: begin
        acc_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(ITER - 1)) ? DONE : MULT;
      end
      DIV: begin
        acc_d   = sum;
        q_d     = {q_q[WIDTH-2:0], ~sum[WIDTH]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(ITER - 1)) ? DFIX : DIV;
      end
      DFIX: begin
        acc_d   = sum;
        state_d = DONE;
      end
      DONE: begin
        rdy_d   = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
        res_d   = div_q ? (dz_q ? '0 : (neg_q ? sum[WIDTH-1:0] : q_q)) : prod[WIDTH-1:0];
        exc_d   = div_q ? (dz_q | dov_q)
                        : !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      end
      default: ;
    endcase
    if (start) begin
      state_d = bus.ctrl_MULT ? MULT : DIV;
      div_d   = ~bus.ctrl_MULT;
      cnt_d   = '0;
      acc_d   = '0;
      qm1_d   = 1'b0;
      q_d     = bus.ctrl_MULT ? bus.data_operandB : mag_a;
      m_d     = bus.ctrl_MULT ? {bus.data_operandA[WIDTH-1], bus.data_operandA} : {1'b0, mag_b};
      neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dz_d    = bus.data_operandB == '0;
      dov_d   = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
    end
  end
  // state and datapath registers; reset discards any operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      dov_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      dov_q   <= dov_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end
  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q != IDLE) || rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed self-checking bench for the multiply/divide unit
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  multdiv_if bus();
  multdiv_unit dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;

  task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!bus.data_resultRDY && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (bus.data_result !== 32'h0) $display("FAIL reset_result got %h want 0", bus.data_result); else passed++;
    total++; if (bus.data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", bus.data_exception); else passed++;
    total++; if (bus.data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", bus.data_resultRDY); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_mult;
    logic [31:0] va[5] = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb[5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'd1, 32'h8000_0000};
    logic [31:0] vr[5] = '{32'hFFFF_FFEB, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0};
    logic ve[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0, va[i], vb[i]);
      total++; if (bus.busy !== 1'b1) $display("FAIL mult%0d_busy got %b want 1", i, bus.busy); else passed++;
      wait_rdy(lat);
      total++; if (lat !== 33) $display("FAIL mult%0d_latency got %0d want 33", i, lat); else passed++;
      total++; if (bus.data_result !== vr[i]) $display("FAIL mult%0d_result got %h want %h", i, bus.data_result, vr[i]); else passed++;
      total++; if (bus.data_exception !== ve[i]) $display("FAIL mult%0d_exc got %b want %b", i, bus.data_exception, ve[i]); else passed++;
      total++; if (bus.busy !== 1'b1) $display("FAIL mult%0d_busy_rdy got %b want 1", i, bus.busy); else passed++;
      @(negedge clock);
      total++; if (bus.data_resultRDY !== 1'b0) $display("FAIL mult%0d_rdy_len got %b want 0", i, bus.data_resultRDY); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL mult%0d_busy_after got %b want 0", i, bus.busy); else passed++;
    end
  endtask

  task automatic test_div;
    logic [31:0] va[6] = '{32'hFFFF_FFF9, 32'd7, 32'd100, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb[6] = '{32'd2, 32'hFFFF_FFFE, 32'd7, 32'd0, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] vr[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_000E, 32'h0, 32'h8000_0000, 32'h8000_0000};
    logic ve[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 1'b1, va[i], vb[i]);
      wait_rdy(lat);
      total++; if (lat !== 34) $display("FAIL div%0d_latency got %0d want 34", i, lat); else passed++;
      total++; if (bus.data_result !== vr[i]) $display("FAIL div%0d_result got %h want %h", i, bus.data_result, vr[i]); else passed++;
      total++; if (bus.data_exception !== ve[i]) $display("FAIL div%0d_exc got %b want %b", i, bus.data_exception, ve[i]); else passed++;
      @(negedge clock);
      total++; if (bus.data_resultRDY !== 1'b0) $display("FAIL div%0d_rdy_len got %b want 0", i, bus.data_resultRDY); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    pulse(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++; if (bus.data_result !== 32'h0) $display("FAIL rstmid_result got %h want 0", bus.data_result); else passed++;
    total++; if (bus.data_exception !== 1'b0) $display("FAIL rstmid_exc got %b want 0", bus.data_exception); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else passed++;
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen |= bus.data_resultRDY | bus.busy;
    end
    total++; if (seen !== 1'b0) $display("FAIL rstmid_no_rdy got %b want 0", seen); else passed++;
  endtask

  task automatic test_abort;
    logic seen = 1'b0;
    int lat;
    pulse(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) begin
      @(negedge clock);
      seen |= bus.data_resultRDY;
    end
    pulse(1'b0, 1'b1, 32'd20, 32'd5);
    wait_rdy(lat);
    total++; if (seen !== 1'b0) $display("FAIL abort_early_rdy got %b want 0", seen); else passed++;
    total++; if (lat !== 34) $display("FAIL abort_latency got %0d want 34", lat); else passed++;
    total++; if (bus.data_result !== 32'd4) $display("FAIL abort_result got %h want 4", bus.data_result); else passed++;
    @(negedge clock);
  endtask

  task automatic test_same_cycle;
    int lat;
    bus.data_operandA = 32'd6;
    bus.data_operandB = 32'd3;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'h0000_DEAD;
    bus.data_operandB = 32'h0000_0077;
    wait_rdy(lat);
    total++; if (lat !== 33) $display("FAIL same_latency got %0d want 33", lat); else passed++;
    total++; if (bus.data_result !== 32'd18) $display("FAIL same_result got %h want 12", bus.data_result); else passed++;
    total++; if (bus.data_exception !== 1'b0) $display("FAIL same_exc got %b want 0", bus.data_exception); else passed++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int lat;
    pulse(1'b1, 1'b0, 32'd5, 32'd5);
    repeat (32) @(negedge clock);
    total++; if (bus.data_resultRDY !== 1'b0) $display("FAIL b2b_rdy_early got %b want 0", bus.data_resultRDY); else passed++;
    pulse(1'b0, 1'b1, 32'd100, 32'd7);
    total++; if (bus.data_resultRDY !== 1'b1) $display("FAIL b2b_rdy_first got %b want 1", bus.data_resultRDY); else passed++;
    total++; if (bus.data_result !== 32'd25) $display("FAIL b2b_result_first got %h want 19", bus.data_result); else passed++;
    @(negedge clock);
    total++; if (bus.data_resultRDY !== 1'b0) $display("FAIL b2b_rdy_gap got %b want 0", bus.data_resultRDY); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", bus.busy); else passed++;
    wait_rdy(lat);
    total++; if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else passed++;
    total++; if (bus.data_result !== 32'd14) $display("FAIL b2b_result_second got %h want e", bus.data_result); else passed++;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_reset_mid();
    test_abort();
    test_same_cycle();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
